// File: rtl/lnrv_biu_arbiter_if.sv
// ---------------------------------------------------------------------------
// lnrv_biu_arbiter_if
//   One cmd/rsp valid-ready bus channel. This is the same shape for the IFU
//   side, the LSU side and the shared BIU side.
//   master : issues commands and consumes responses (IFU, LSU, or the arbiter
//            toward the BIU)
//   slave  : accepts commands and produces responses (the arbiter toward
//            IFU/LSU, or the BIU itself)
//   cmd_vld/rdy     handshake
//   cmd_write       1 = store, 0 = load
//   cmd_addr/wdata  32-bit address / write data
//   cmd_wstrb       byte strobes
//   cmd_size        access size code
//   rsp_vld/rdy     handshake
//   rsp_rdata/err   read data / error flag
// ---------------------------------------------------------------------------
interface lnrv_biu_arbiter_if;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_size;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_vld, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_size, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_vld, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_size, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lnrv_biu_arbiter.sv
// ---------------------------------------------------------------------------
// lnrv_biu_arbiter
//   Shares one BIU port between the IFU (ID 0) and the LSU (ID 1). A command
//   is forwarded combinationally. The owner ID of each accepted command is
//   queued, so that the in-order responses can be routed back to the owner.
//
//   Optional feature: define LNRV_BIU_ARB_RR_EN to get round-robin arbitration.
//   The default is fixed priority, with the LSU ahead of the IFU.
//
// Ports
//   clk       core clock
//   reset_n   async reset, active low
//   ifu       slave side toward the instruction fetcher
//   lsu       slave side toward the load/store unit
//   biu       master side toward the shared bus interface unit
//   arb_busy  at least one command is outstanding
// ---------------------------------------------------------------------------
module lnrv_biu_arbiter #(
  parameter int OUTS_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  lnrv_biu_arbiter_if.slave          ifu,
  lnrv_biu_arbiter_if.slave          lsu,
  lnrv_biu_arbiter_if.master         biu,
  output logic                       arb_busy
);

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH) + 1;

  logic [OUTS_DEPTH-1:0] id_q;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  lock_q, lock_d;
  logic                  lock_id_q, lock_id_d;

  logic full, empty;
  logic gnt_vld, gnt_id;
  logic cmd_hs, rsp_hs;
  logic head_id, ifu_sel, lsu_sel;

  assign full  = (cnt_q == CW'(OUTS_DEPTH));
  assign empty = (cnt_q == '0);

`ifdef LNRV_BIU_ARB_RR_EN
  logic last_q;
`endif

  // Grant selection. While the lock is set, the stalled owner keeps the port,
  // so the payload seen by the slave cannot change under it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (lock_q) begin
      gnt_id  = lock_id_q;
      gnt_vld = lock_id_q ? lsu.cmd_vld : ifu.cmd_vld;
    end else if (ifu.cmd_vld && lsu.cmd_vld) begin
      gnt_vld = 1'b1;
`ifdef LNRV_BIU_ARB_RR_EN
      gnt_id  = ~last_q;
`else
      gnt_id  = 1'b1;
`endif
    end else if (lsu.cmd_vld) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end else if (ifu.cmd_vld) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end
  end

  // Command path. The payload is zeroed when nobody is granted.
  assign biu.cmd_vld   = gnt_vld & ~full;
  assign biu.cmd_write = gnt_vld & (gnt_id ? lsu.cmd_write : ifu.cmd_write);
  assign biu.cmd_addr  = !gnt_vld ? '0 : (gnt_id ? lsu.cmd_addr  : ifu.cmd_addr);
  assign biu.cmd_wdata = !gnt_vld ? '0 : (gnt_id ? lsu.cmd_wdata : ifu.cmd_wdata);
  assign biu.cmd_wstrb = !gnt_vld ? '0 : (gnt_id ? lsu.cmd_wstrb : ifu.cmd_wstrb);
  assign biu.cmd_size  = !gnt_vld ? '0 : (gnt_id ? lsu.cmd_size  : ifu.cmd_size);

  assign ifu.cmd_rdy = gnt_vld & ~gnt_id & biu.cmd_rdy & ~full;
  assign lsu.cmd_rdy = gnt_vld &  gnt_id & biu.cmd_rdy & ~full;

  assign cmd_hs = biu.cmd_vld & biu.cmd_rdy;

  // Response path. The FIFO head picks the owner. Nothing is routed while the
  // FIFO is empty, so a stray slave response is never acknowledged.
  assign head_id = id_q[rptr_q];
  assign ifu_sel = ~empty & ~head_id;
  assign lsu_sel = ~empty &  head_id;

  assign ifu.rsp_vld   = ifu_sel & biu.rsp_vld;
  assign ifu.rsp_rdata = ifu_sel ? biu.rsp_rdata : '0;
  assign ifu.rsp_err   = ifu_sel & biu.rsp_err;
  assign lsu.rsp_vld   = lsu_sel & biu.rsp_vld;
  assign lsu.rsp_rdata = lsu_sel ? biu.rsp_rdata : '0;
  assign lsu.rsp_err   = lsu_sel & biu.rsp_err;
  assign biu.rsp_rdy   = (ifu_sel & ifu.rsp_rdy) | (lsu_sel & lsu.rsp_rdy);

  assign rsp_hs = biu.rsp_vld & biu.rsp_rdy;

  assign arb_busy = ~empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d    = cmd_hs ? ptr_inc(wptr_q) : wptr_q;
    rptr_d    = rsp_hs ? ptr_inc(rptr_q) : rptr_q;
    cnt_d     = cnt_q;
    case ({cmd_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // A command that is offered but not taken pins the grant for the next cycle.
    lock_d    = biu.cmd_vld & ~biu.cmd_rdy;
    lock_id_d = lock_d ? gnt_id : lock_id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      if (cmd_hs) id_q[wptr_q] <= gnt_id;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

`ifdef LNRV_BIU_ARB_RR_EN
  // Records the last granted ID, so the other requester wins the next conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_q <= 1'b0;
    else if (cmd_hs) last_q <= gnt_id;
  end
`endif

endmodule

// File: tb/tb_lnrv_biu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lnrv_biu_arbiter
//   Directed bench for lnrv_biu_arbiter with OUTS_DEPTH=2. Inputs change 1
//   time unit after the rising edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lnrv_biu_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic arb_busy;
  int   vec = 0;
  int   bad = 0;

  lnrv_biu_arbiter_if ifu_bus();
  lnrv_biu_arbiter_if lsu_bus();
  lnrv_biu_arbiter_if biu_bus();

  lnrv_biu_arbiter #(.OUTS_DEPTH(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ifu      (ifu_bus),
    .lsu      (lsu_bus),
    .biu      (biu_bus),
    .arb_busy (arb_busy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ifu_bus.cmd_vld = 0; ifu_bus.cmd_write = 0; ifu_bus.cmd_addr = 0; ifu_bus.cmd_wdata = 0;
    ifu_bus.cmd_wstrb = 0; ifu_bus.cmd_size = 0; ifu_bus.rsp_rdy = 0;
    lsu_bus.cmd_vld = 0; lsu_bus.cmd_write = 0; lsu_bus.cmd_addr = 0; lsu_bus.cmd_wdata = 0;
    lsu_bus.cmd_wstrb = 0; lsu_bus.cmd_size = 0; lsu_bus.rsp_rdy = 0;
    biu_bus.cmd_rdy = 0; biu_bus.rsp_vld = 0; biu_bus.rsp_rdata = 0; biu_bus.rsp_err = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #1;
    vec++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", arb_busy); end
    vec++; if (biu_bus.cmd_vld !== 1'b0) begin bad++; $display("FAIL rst_cmd_vld: got %b want 0", biu_bus.cmd_vld); end
    vec++; if (biu_bus.rsp_rdy !== 1'b0) begin bad++; $display("FAIL rst_rsp_rdy: got %b want 0", biu_bus.rsp_rdy); end
    vec++; if (biu_bus.cmd_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", biu_bus.cmd_addr); end
    @(negedge clk); reset_n = 1'b1;
    next_cyc();
  endtask

  task automatic test_ifu_only();
    ifu_bus.cmd_vld = 1; ifu_bus.cmd_addr = 32'h8000_0000; ifu_bus.cmd_size = 3'd2;
    ifu_bus.cmd_wstrb = 4'hf; biu_bus.cmd_rdy = 1;
    @(negedge clk);
    vec++; if (biu_bus.cmd_vld !== 1'b1) begin bad++; $display("FAIL t1_cmd_vld: got %b want 1", biu_bus.cmd_vld); end
    vec++; if (biu_bus.cmd_addr !== 32'h8000_0000) begin bad++; $display("FAIL t1_addr: got %h want 80000000", biu_bus.cmd_addr); end
    vec++; if (biu_bus.cmd_size !== 3'd2) begin bad++; $display("FAIL t1_size: got %0d want 2", biu_bus.cmd_size); end
    vec++; if (ifu_bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL t1_ifu_rdy: got %b want 1", ifu_bus.cmd_rdy); end
    vec++; if (lsu_bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL t1_lsu_rdy: got %b want 0", lsu_bus.cmd_rdy); end
    next_cyc();
    idle();
    vec++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL t1_busy: got %b want 1", arb_busy); end
    biu_bus.rsp_vld = 1; biu_bus.rsp_rdata = 32'h0000_0013; ifu_bus.rsp_rdy = 1; lsu_bus.rsp_rdy = 1;
    @(negedge clk);
    vec++; if (ifu_bus.rsp_vld !== 1'b1) begin bad++; $display("FAIL t1_ifu_rsp_vld: got %b want 1", ifu_bus.rsp_vld); end
    vec++; if (ifu_bus.rsp_rdata !== 32'h13) begin bad++; $display("FAIL t1_ifu_rdata: got %h want 13", ifu_bus.rsp_rdata); end
    vec++; if (lsu_bus.rsp_vld !== 1'b0) begin bad++; $display("FAIL t1_lsu_rsp_vld: got %b want 0", lsu_bus.rsp_vld); end
    vec++; if (lsu_bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL t1_lsu_rdata: got %h want 0", lsu_bus.rsp_rdata); end
    vec++; if (biu_bus.rsp_rdy !== 1'b1) begin bad++; $display("FAIL t1_biu_rsp_rdy: got %b want 1", biu_bus.rsp_rdy); end
    next_cyc();
    idle();
    vec++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL t1_idle: got %b want 0", arb_busy); end
  endtask

  // Both requesters want the bus every cycle. One response per cycle keeps a
  // single command outstanding, so the FIFO never fills.
  task automatic test_conflict();
    logic exp_lsu;
    ifu_bus.cmd_vld = 1; ifu_bus.cmd_addr = 32'h1000;
    lsu_bus.cmd_vld = 1; lsu_bus.cmd_addr = 32'h2000;
    biu_bus.cmd_rdy = 1; biu_bus.rsp_vld = 1; biu_bus.rsp_rdata = 32'hAA;
    ifu_bus.rsp_rdy = 1; lsu_bus.rsp_rdy = 1;
    exp_lsu = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef LNRV_BIU_ARB_RR_EN
      exp_lsu = (i % 2 == 0);
`endif
      @(negedge clk);
      vec++; if (lsu_bus.cmd_rdy !== exp_lsu) begin bad++; $display("FAIL t2_lsu_rdy[%0d]: got %b want %b", i, lsu_bus.cmd_rdy, exp_lsu); end
      vec++; if (ifu_bus.cmd_rdy !== !exp_lsu) begin bad++; $display("FAIL t2_ifu_rdy[%0d]: got %b want %b", i, ifu_bus.cmd_rdy, !exp_lsu); end
      vec++; if (biu_bus.cmd_addr !== (exp_lsu ? 32'h2000 : 32'h1000)) begin bad++; $display("FAIL t2_addr[%0d]: got %h", i, biu_bus.cmd_addr); end
      next_cyc();
    end
    ifu_bus.cmd_vld = 0; lsu_bus.cmd_vld = 0;
    @(negedge clk);
    vec++; if (lsu_bus.rsp_vld !== exp_lsu) begin bad++; $display("FAIL t2_drain_route: got %b want %b", lsu_bus.rsp_vld, exp_lsu); end
    next_cyc();
    idle();
    vec++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL t2_idle: got %b want 0", arb_busy); end
  endtask

  task automatic test_stall_lock();
    ifu_bus.cmd_vld = 1; ifu_bus.cmd_addr = 32'h3000; biu_bus.cmd_rdy = 0;
    @(negedge clk);
    vec++; if (biu_bus.cmd_addr !== 32'h3000) begin bad++; $display("FAIL t3_addr0: got %h want 3000", biu_bus.cmd_addr); end
    vec++; if (ifu_bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL t3_ifu_rdy0: got %b want 0", ifu_bus.cmd_rdy); end
    next_cyc();
    lsu_bus.cmd_vld = 1; lsu_bus.cmd_addr = 32'h4000;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      vec++; if (biu_bus.cmd_addr !== 32'h3000) begin bad++; $display("FAIL t3_addr%0d: got %h want 3000", i, biu_bus.cmd_addr); end
      vec++; if (lsu_bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL t3_lsu_rdy%0d: got %b want 0", i, lsu_bus.cmd_rdy); end
      next_cyc();
    end
    biu_bus.cmd_rdy = 1;
    @(negedge clk);
    vec++; if (ifu_bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL t3_ifu_hs: got %b want 1", ifu_bus.cmd_rdy); end
    vec++; if (biu_bus.cmd_addr !== 32'h3000) begin bad++; $display("FAIL t3_addr_hs: got %h want 3000", biu_bus.cmd_addr); end
    next_cyc();
    ifu_bus.cmd_vld = 0;
    @(negedge clk);
    vec++; if (lsu_bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL t3_lsu_hs: got %b want 1", lsu_bus.cmd_rdy); end
    vec++; if (biu_bus.cmd_addr !== 32'h4000) begin bad++; $display("FAIL t3_lsu_addr: got %h want 4000", biu_bus.cmd_addr); end
    next_cyc();
    idle();
  endtask

  // This test starts with two commands (IFU, then LSU) left outstanding by test_stall_lock.
  task automatic test_full();
    ifu_bus.cmd_vld = 1; ifu_bus.cmd_addr = 32'h5000; biu_bus.cmd_rdy = 1;
    @(negedge clk);
    vec++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL t4_busy: got %b want 1", arb_busy); end
    vec++; if (biu_bus.cmd_vld !== 1'b0) begin bad++; $display("FAIL t4_full_vld: got %b want 0", biu_bus.cmd_vld); end
    vec++; if (ifu_bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL t4_full_rdy: got %b want 0", ifu_bus.cmd_rdy); end
    next_cyc();
    biu_bus.rsp_vld = 1; biu_bus.rsp_rdata = 32'h11; ifu_bus.rsp_rdy = 1;
    @(negedge clk);
    vec++; if (ifu_bus.rsp_vld !== 1'b1) begin bad++; $display("FAIL t4_pop_vld: got %b want 1", ifu_bus.rsp_vld); end
    vec++; if (biu_bus.rsp_rdy !== 1'b1) begin bad++; $display("FAIL t4_pop_rdy: got %b want 1", biu_bus.rsp_rdy); end
    vec++; if (ifu_bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL t4_same_cyc: got %b want 0", ifu_bus.cmd_rdy); end
    next_cyc();
    biu_bus.rsp_vld = 0;
    @(negedge clk);
    vec++; if (ifu_bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL t4_after_pop: got %b want 1", ifu_bus.cmd_rdy); end
    vec++; if (biu_bus.cmd_addr !== 32'h5000) begin bad++; $display("FAIL t4_addr: got %h want 5000", biu_bus.cmd_addr); end
    next_cyc();
    ifu_bus.cmd_vld = 0;
    biu_bus.rsp_vld = 1; biu_bus.rsp_rdata = 32'h22; ifu_bus.rsp_rdy = 1; lsu_bus.rsp_rdy = 1;
    @(negedge clk);
    vec++; if (lsu_bus.rsp_vld !== 1'b1) begin bad++; $display("FAIL t4_lsu_rsp: got %b want 1", lsu_bus.rsp_vld); end
    vec++; if (lsu_bus.rsp_rdata !== 32'h22) begin bad++; $display("FAIL t4_lsu_rdata: got %h want 22", lsu_bus.rsp_rdata); end
    vec++; if (ifu_bus.rsp_vld !== 1'b0) begin bad++; $display("FAIL t4_ifu_quiet: got %b want 0", ifu_bus.rsp_vld); end
    next_cyc();
    biu_bus.rsp_rdata = 32'h33;
    @(negedge clk);
    vec++; if (ifu_bus.rsp_rdata !== 32'h33) begin bad++; $display("FAIL t4_ifu_rdata: got %h want 33", ifu_bus.rsp_rdata); end
    next_cyc();
    idle();
    vec++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL t4_idle: got %b want 0", arb_busy); end
  endtask

  task automatic test_ordering();
    biu_bus.cmd_rdy = 1;
    ifu_bus.cmd_vld = 1; ifu_bus.cmd_addr = 32'h6000;
    @(negedge clk);
    vec++; if (ifu_bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL t5_c0: got %b want 1", ifu_bus.cmd_rdy); end
    next_cyc();
    ifu_bus.cmd_vld = 0; lsu_bus.cmd_vld = 1; lsu_bus.cmd_addr = 32'h7000;
    @(negedge clk);
    vec++; if (lsu_bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL t5_c1: got %b want 1", lsu_bus.cmd_rdy); end
    next_cyc();
    lsu_bus.cmd_vld = 0;
    biu_bus.rsp_vld = 1; biu_bus.rsp_rdata = 32'hD0; biu_bus.rsp_err = 0;
    ifu_bus.rsp_rdy = 1; lsu_bus.rsp_rdy = 0;
    @(negedge clk);
    vec++; if (ifu_bus.rsp_rdata !== 32'hD0) begin bad++; $display("FAIL t5_d0: got %h want d0", ifu_bus.rsp_rdata); end
    vec++; if (lsu_bus.rsp_vld !== 1'b0) begin bad++; $display("FAIL t5_d0_lsu: got %b want 0", lsu_bus.rsp_vld); end
    next_cyc();
    ifu_bus.cmd_vld = 1; ifu_bus.cmd_addr = 32'h6004;
    biu_bus.rsp_rdata = 32'hD1; biu_bus.rsp_err = 1;
    @(negedge clk);
    vec++; if (lsu_bus.rsp_vld !== 1'b1) begin bad++; $display("FAIL t5_d1_vld: got %b want 1", lsu_bus.rsp_vld); end
    vec++; if (lsu_bus.rsp_err !== 1'b1) begin bad++; $display("FAIL t5_d1_err: got %b want 1", lsu_bus.rsp_err); end
    vec++; if (ifu_bus.rsp_err !== 1'b0) begin bad++; $display("FAIL t5_d1_ifu_err: got %b want 0", ifu_bus.rsp_err); end
    vec++; if (biu_bus.rsp_rdy !== 1'b0) begin bad++; $display("FAIL t5_bp: got %b want 0", biu_bus.rsp_rdy); end
    vec++; if (ifu_bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL t5_c2: got %b want 1", ifu_bus.cmd_rdy); end
    next_cyc();
    ifu_bus.cmd_vld = 0; lsu_bus.rsp_rdy = 1;
    @(negedge clk);
    vec++; if (biu_bus.rsp_rdy !== 1'b1) begin bad++; $display("FAIL t5_d1_rdy: got %b want 1", biu_bus.rsp_rdy); end
    vec++; if (lsu_bus.rsp_rdata !== 32'hD1) begin bad++; $display("FAIL t5_d1_data: got %h want d1", lsu_bus.rsp_rdata); end
    next_cyc();
    biu_bus.rsp_rdata = 32'hD2; biu_bus.rsp_err = 0;
    @(negedge clk);
    vec++; if (ifu_bus.rsp_vld !== 1'b1) begin bad++; $display("FAIL t5_d2_vld: got %b want 1", ifu_bus.rsp_vld); end
    vec++; if (ifu_bus.rsp_rdata !== 32'hD2) begin bad++; $display("FAIL t5_d2_data: got %h want d2", ifu_bus.rsp_rdata); end
    vec++; if (lsu_bus.rsp_vld !== 1'b0) begin bad++; $display("FAIL t5_d2_lsu: got %b want 0", lsu_bus.rsp_vld); end
    next_cyc();
    idle();
    vec++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL t5_idle: got %b want 0", arb_busy); end
  endtask

  task automatic test_reset_mid();
    ifu_bus.cmd_vld = 1; ifu_bus.cmd_addr = 32'h9000; biu_bus.cmd_rdy = 1;
    next_cyc();
    idle();
    vec++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL t6_pre: got %b want 1", arb_busy); end
    biu_bus.rsp_vld = 1; biu_bus.rsp_rdata = 32'hEE; ifu_bus.rsp_rdy = 1; lsu_bus.rsp_rdy = 1;
    #2 reset_n = 1'b0;
    #1;
    vec++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL t6_busy: got %b want 0", arb_busy); end
    vec++; if (ifu_bus.rsp_vld !== 1'b0) begin bad++; $display("FAIL t6_rsp_vld: got %b want 0", ifu_bus.rsp_vld); end
    vec++; if (ifu_bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL t6_rdata: got %h want 0", ifu_bus.rsp_rdata); end
    vec++; if (biu_bus.rsp_rdy !== 1'b0) begin bad++; $display("FAIL t6_rsp_rdy: got %b want 0", biu_bus.rsp_rdy); end
    vec++; if (biu_bus.cmd_vld !== 1'b0) begin bad++; $display("FAIL t6_cmd_vld: got %b want 0", biu_bus.cmd_vld); end
    @(negedge clk); reset_n = 1'b1;
    next_cyc();
    vec++; if (biu_bus.rsp_rdy !== 1'b0) begin bad++; $display("FAIL t6_spurious: got %b want 0", biu_bus.rsp_rdy); end
    vec++; if (ifu_bus.rsp_vld !== 1'b0) begin bad++; $display("FAIL t6_spur_vld: got %b want 0", ifu_bus.rsp_vld); end
    next_cyc();
    vec++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL t6_after: got %b want 0", arb_busy); end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ifu_only();
    test_conflict();
    test_stall_lock();
    test_full();
    test_ordering();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
